// File: rtl/tia_horizontal_decode.sv
// Horizontal line-timing decode of the TIA LFSR count: HSYNC, HBLANK, colour burst,
// HMOVE late-blank extension and the WSYNC RDY latch. Optional centre pulse: TIA_HDECODE_CNT_EN.
module tia_horizontal_decode #(
  parameter logic [5:0] SHS_VAL  = 6'b111100,
  parameter logic [5:0] RHS_VAL  = 6'b110111,
  parameter logic [5:0] RCB_VAL  = 6'b001111,
  parameter logic [5:0] RHB_VAL  = 6'b011100,
  parameter logic [5:0] LRHB_VAL = 6'b010111
`ifdef TIA_HDECODE_CNT_EN
  , parameter logic [5:0] CNT_VAL = 6'b101100
`endif
) (
  input  logic       clk,
  input  logic       resl,
  input  logic       cnt_en,
  input  logic [5:0] lfsr,
  input  logic       shb,
  input  logic       hmove,
  input  logic       wsync,
  output logic       hsync,
  output logic       hblank,
  output logic       cburst,
  output logic       hmove_ext,
  output logic       rdy
`ifdef TIA_HDECODE_CNT_EN
  , output logic     cnt
`endif
);

  logic hsync_q, hsync_d;
  logic hblank_q, hblank_d;
  logic cburst_q, cburst_d;
  logic hmove_ext_q, hmove_ext_d;
  logic pending_q, pending_d;
  logic rdy_q, rdy_d;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path
    // through the if/case tree leaves it unassigned and no latch is inferred.
    hsync_d     = hsync_q;
    hblank_d    = hblank_q;
    cburst_d    = cburst_q;
    hmove_ext_d = hmove_ext_q;
    pending_d   = pending_q;
    rdy_d       = rdy_q;

    if (hmove) pending_d = 1'b1;
    if (wsync) rdy_d = 1'b0;

    if (cnt_en) begin
      if (shb) begin
        // Line wrap overrides any count match and any coincident WSYNC.
        hblank_d = 1'b1;
        rdy_d    = 1'b1;
        if (pending_q || hmove) begin
          hmove_ext_d = 1'b1;
          pending_d   = 1'b0;
        end else begin
          hmove_ext_d = 1'b0;
        end
      end else begin
        unique case (lfsr)
          SHS_VAL: hsync_d = 1'b1;
          RHS_VAL: begin
            hsync_d  = 1'b0;
            cburst_d = 1'b1;
          end
          RCB_VAL:  cburst_d = 1'b0;
          RHB_VAL:  if (!hmove_ext_q) hblank_d = 1'b0;
          LRHB_VAL: if (hmove_ext_q) hblank_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      hsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      cburst_q    <= 1'b0;
      hmove_ext_q <= 1'b0;
      pending_q   <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      hsync_q     <= hsync_d;
      hblank_q    <= hblank_d;
      cburst_q    <= cburst_d;
      hmove_ext_q <= hmove_ext_d;
      pending_q   <= pending_d;
      rdy_q       <= rdy_d;
    end
  end

  assign hsync     = hsync_q;
  assign hblank    = hblank_q;
  assign cburst    = cburst_q;
  assign hmove_ext = hmove_ext_q;
  assign rdy       = rdy_q;

`ifdef TIA_HDECODE_CNT_EN
  logic cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_en && !shb && (lfsr == CNT_VAL);
  end

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) cnt_q <= 1'b0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tia_horizontal_decode.sv
// Directed bench for tia_horizontal_decode: whole-line walks driven by an LFSR model,
// a table of corner-case vectors, and hand-written reset / hold sequences.
module tb_tia_horizontal_decode;

  logic       clk = 1'b0;
  logic       resl;
  logic       cnt_en, shb, hmove, wsync;
  logic [5:0] lfsr;
  logic       hsync, hblank, cburst, hmove_ext, rdy;
`ifdef TIA_HDECODE_CNT_EN
  logic       cnt;
`endif

  int checks = 0;
  int errors = 0;

  tia_horizontal_decode dut (
    .clk       (clk),
    .resl      (resl),
    .cnt_en    (cnt_en),
    .lfsr      (lfsr),
    .shb       (shb),
    .hmove     (hmove),
    .wsync     (wsync),
    .hsync     (hsync),
    .hblank    (hblank),
    .cburst    (cburst),
    .hmove_ext (hmove_ext),
    .rdy       (rdy)
`ifdef TIA_HDECODE_CNT_EN
    , .cnt     (cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: {hsync, hblank, cburst, hmove_ext, rdy}
  typedef struct packed {
    logic       ce;
    logic [5:0] l;
    logic       shb;
    logic       hm;
    logic       ws;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [5:0] lfsr_next(input logic [5:0] l);
    return {~(l[0] ^ l[1]), l[5:1]};
  endfunction

  function automatic vec_t mk(input logic ce, input logic [5:0] l, input logic s,
                              input logic hm, input logic ws, input logic [4:0] e);
    vec_t v;
    v.ce = ce; v.l = l; v.shb = s; v.hm = hm; v.ws = ws; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {hs,hb,cb,ext,rdy}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {hsync, hblank, cburst, hmove_ext, rdy};
  endfunction

  task automatic cycle(input logic ce, input logic [5:0] l, input logic s,
                       input logic hm, input logic ws);
    cnt_en = ce; lfsr = l; shb = s; hmove = hm; wsync = ws;
    @(posedge clk);
    #1;
    cnt_en = 1'b0; shb = 1'b0; hmove = 1'b0; wsync = 1'b0;
  endtask

  // Walk steps 1..56 of a line that began with a wrap; hm_step/ws_step < 0 means none.
  task automatic run_line(input string tag, input logic ext, input int hm_step, input int ws_step);
    logic [5:0] l;
    logic [4:0] e;
    l = 6'b000000;
    for (int s = 1; s <= 56; s++) begin
      l = lfsr_next(l);
      cycle(1'b1, l, 1'b0, s == hm_step, s == ws_step);
      e[4] = (s >= 4) && (s < 8);
      e[3] = ext ? (s < 18) : (s < 16);
      e[2] = (s >= 8) && (s < 12);
      e[1] = ext;
      e[0] = !((ws_step > 0) && (s >= ws_step));
      check($sformatf("%s step %0d lfsr %b", tag, s, l), outs(), e);
      // Idle edge presenting a decodable count must be ignored.
      cycle(1'b0, 6'b011100, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    resl = 1'b0; cnt_en = 1'b0; lfsr = '0; shb = 1'b0; hmove = 1'b0; wsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", outs(), 5'b01001);
    resl = 1'b1;

    cycle(1'b0, 6'b111100, 1'b0, 1'b0, 1'b0);
    check("idle after reset", outs(), 5'b01001);

    // Normal line with WSYNC at step 20, then wrap restores rdy.
    cycle(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
    check("first wrap", outs(), 5'b01001);
    run_line("line_wsync", 1'b0, -1, 20);
    cycle(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
    check("wrap releases rdy", outs(), 5'b01001);

    // HMOVE mid-line extends the following line.
    run_line("line_hmove", 1'b0, 30, -1);
    cycle(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
    check("wrap after hmove", outs(), 5'b01011);
    run_line("line_ext", 1'b1, -1, -1);
    cycle(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
    check("wrap without hmove", outs(), 5'b01001);

    tbl[0]  = mk(1'b0, 6'b111100, 1'b0, 1'b0, 1'b0, 5'b01001);
    tbl[1]  = mk(1'b1, 6'b111100, 1'b0, 1'b0, 1'b0, 5'b11001);
    tbl[2]  = mk(1'b1, 6'b111111, 1'b0, 1'b0, 1'b0, 5'b11001);
    tbl[3]  = mk(1'b0, 6'b110111, 1'b0, 1'b0, 1'b1, 5'b11000);
    tbl[4]  = mk(1'b1, 6'b110111, 1'b1, 1'b0, 1'b1, 5'b11001);
    tbl[5]  = mk(1'b1, 6'b110111, 1'b0, 1'b0, 1'b0, 5'b01101);
    tbl[6]  = mk(1'b0, 6'b001111, 1'b0, 1'b1, 1'b0, 5'b01101);
    tbl[7]  = mk(1'b0, 6'b001111, 1'b0, 1'b1, 1'b0, 5'b01101);
    tbl[8]  = mk(1'b1, 6'b001111, 1'b0, 1'b0, 1'b0, 5'b01001);
    tbl[9]  = mk(1'b1, 6'b011100, 1'b1, 1'b0, 1'b0, 5'b01011);
    tbl[10] = mk(1'b1, 6'b011100, 1'b0, 1'b0, 1'b0, 5'b01011);
    tbl[11] = mk(1'b1, 6'b010111, 1'b0, 1'b0, 1'b0, 5'b00011);
    tbl[12] = mk(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0, 5'b01001);
    tbl[13] = mk(1'b1, 6'b000000, 1'b1, 1'b1, 1'b0, 5'b01011);
    tbl[14] = mk(1'b1, 6'b010111, 1'b1, 1'b0, 1'b0, 5'b01001);
    tbl[15] = mk(1'b1, 6'b011100, 1'b0, 1'b0, 1'b0, 5'b00001);
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].ce, tbl[i].l, tbl[i].shb, tbl[i].hm, tbl[i].ws);
      check($sformatf("vector %0d", i), outs(), tbl[i].exp);
    end

    // Held SHS count without cnt_en must not set hsync.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 6'b111100, 1'b0, 1'b0, 1'b0);
      check($sformatf("hold shs %0d", i), outs(), 5'b00001);
    end
    cycle(1'b1, 6'b111100, 1'b0, 1'b0, 1'b0);
    check("shs strobe", outs(), 5'b10001);

    // Mid-line async reset after step 6, with rdy already pulled low.
    begin
      logic [5:0] l;
      cycle(1'b1, 6'b000000, 1'b1, 1'b0, 1'b0);
      l = 6'b000000;
      for (int s = 1; s <= 6; s++) begin
        l = lfsr_next(l);
        cycle(1'b1, l, 1'b0, 1'b0, s == 5);
      end
      check("before mid-line reset", outs(), 5'b11000);
      #2;
      resl = 1'b0;
      #1;
      check("async reset", outs(), 5'b01001);
      @(posedge clk);
      #1;
      check("held in reset", outs(), 5'b01001);
      resl = 1'b1;
      cycle(1'b1, 6'b110111, 1'b0, 1'b0, 1'b0);
      check("resume at rhs", outs(), 5'b01101);
    end

`ifdef TIA_HDECODE_CNT_EN
    cycle(1'b1, 6'b101100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 1'b1) begin errors++; $display("FAIL cnt pulse: got %b expected 1", cnt); end
    cycle(1'b0, 6'b101100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 1'b0) begin errors++; $display("FAIL cnt one clk: got %b expected 0", cnt); end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
